// File: rtl/score_text_if.sv
// Bus bundle between the score text buffer and its reader/score source.
// The master drives the read address and score updates; the slave returns codes and status.
interface score_text_if;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic [7:0] score_l;
    logic [7:0] score_r;
    logic       score_valid;
    logic       busy;
    logic       done;

    modport master (
        output char_xy, score_l, score_r, score_valid,
        input  char_code, busy, done
    );

    modport slave (
        input  char_xy, score_l, score_r, score_valid,
        output char_code, busy, done
    );
endinterface

// File: rtl/score_text_buffer.sv
// 16x16 character buffer for the score overlay with a clear/format FSM rewriting row 0.
// Optional macro SCORE_BLANK_ZERO_EN enables leading-zero suppression of score digits.
module score_text_buffer #(
    parameter logic [6:0] BLANK_CODE = 7'h20,
    parameter int         CONV_BITS  = 8
) (
    input logic         pclk,
    input logic         rst,
    score_text_if.slave bus
);
    localparam int SW = 12 + CONV_BITS;

    typedef enum logic [2:0] {S_CLEAR, S_LABELS, S_CONV, S_WRITE, S_IDLE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic [SW-1:0]     sh_l_q, sh_r_q;
    logic [7:0]        lat_l_q, lat_r_q;
    logic [6:0]        ram_q [256];
    logic [6:0]        char_code_q;

    logic              we;
    logic [7:0]        waddr;
    logic [6:0]        wdata;
    logic              load_live, load_lat, conv_en, latch_en;
    logic [11:0]       bcd;
    logic              hz, tz;

    // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift the whole word.
    function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] v);
        logic [SW-1:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[CONV_BITS+4*i +: 4] >= 4'd5)
                t[CONV_BITS+4*i +: 4] = t[CONV_BITS+4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    function automatic logic [6:0] digit_code(input logic [3:0] d, input logic blank);
        return blank ? BLANK_CODE : (7'h30 + {3'b000, d});
    endfunction

    always_comb begin
        bcd = (cnt_q >= 8'd3) ? sh_r_q[SW-1 -: 12] : sh_l_q[SW-1 -: 12];
`ifdef SCORE_BLANK_ZERO_EN
        hz = (bcd[11:8] == 4'd0);
        tz = hz && (bcd[7:4] == 4'd0);
`else
        hz = 1'b0;
        tz = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        pending_d = pending_q;
        done_d    = 1'b0;
        we        = 1'b0;
        waddr     = cnt_q;
        wdata     = BLANK_CODE;
        load_live = 1'b0;
        load_lat  = 1'b0;
        conv_en   = 1'b0;
        latch_en  = 1'b0;

        if (state_q != S_IDLE && bus.score_valid) begin
            latch_en  = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            S_CLEAR: begin
                we = 1'b1;
                if (cnt_q == 8'd255) state_d = S_LABELS;
            end
            S_LABELS: begin
                we = 1'b1;
                case (cnt_q)
                    8'd0:    begin waddr = 8'h00; wdata = 7'h4C; end
                    8'd1:    begin waddr = 8'h01; wdata = 7'h3A; end
                    8'd2:    begin waddr = 8'h0B; wdata = 7'h52; end
                    default: begin waddr = 8'h0C; wdata = 7'h3A; end
                endcase
                if (cnt_q == 8'd3) begin
                    load_live = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                conv_en = 1'b1;
                if (cnt_q == 8'(CONV_BITS - 1)) begin
                    cnt_d   = 8'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                we = 1'b1;
                case (cnt_q)
                    8'd0:    begin waddr = 8'h02; wdata = digit_code(bcd[11:8], hz); end
                    8'd1:    begin waddr = 8'h03; wdata = digit_code(bcd[7:4],  tz); end
                    8'd2:    begin waddr = 8'h04; wdata = digit_code(bcd[3:0],  1'b0); end
                    8'd3:    begin waddr = 8'h0D; wdata = digit_code(bcd[11:8], hz); end
                    8'd4:    begin waddr = 8'h0E; wdata = digit_code(bcd[7:4],  tz); end
                    default: begin waddr = 8'h0F; wdata = digit_code(bcd[3:0],  1'b0); end
                endcase
                if (cnt_q == 8'd5) begin
                    cnt_d  = 8'd0;
                    done_d = 1'b1;
                    // A request arriving on the very last write is newer than anything latched.
                    if (bus.score_valid) begin
                        load_live = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_CONV;
                    end else if (pending_q) begin
                        load_lat  = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_CONV;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d = 8'd0;
                if (bus.score_valid) begin
                    load_live = 1'b1;
                    state_d   = S_CONV;
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            cnt_q     <= 8'd0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (load_live) begin
            sh_l_q <= SW'(bus.score_l);
            sh_r_q <= SW'(bus.score_r);
        end else if (load_lat) begin
            sh_l_q <= SW'(lat_l_q);
            sh_r_q <= SW'(lat_r_q);
        end else if (conv_en) begin
            sh_l_q <= dd_step(sh_l_q);
            sh_r_q <= dd_step(sh_r_q);
        end
        if (latch_en) begin
            lat_l_q <= bus.score_l;
            lat_r_q <= bus.score_r;
        end
    end

    always_ff @(posedge pclk) begin
        if (we) ram_q[waddr] <= wdata;
    end

    // Non-blocking read of the array gives old data on a same-address write.
    always_ff @(posedge pclk) begin
        if (rst) char_code_q <= 7'd0;
        else     char_code_q <= ram_q[bus.char_xy];
    end

    assign bus.char_code = char_code_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_score_text_buffer.sv
// Directed, table-driven bench for score_text_buffer: boot, updates, pending chain,
// read collision and reset mid-conversion.
module tb_score_text_buffer;
    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    score_text_if bus();

    score_text_buffer dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [6:0] exp;
    } rd_t;

    typedef struct {
        logic [7:0]       sl;
        logic [7:0]       sr;
        logic [5:0][6:0]  exp;
    } vec_t;

    rd_t  boot_tbl [19];
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [6:0] c);
        bus.char_xy = a;
        step();
        c = bus.char_code;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic update(input logic [7:0] l, input logic [7:0] r);
        bus.score_l     = l;
        bus.score_r     = r;
        bus.score_valid = 1'b1;
        step();
        bus.score_valid = 1'b0;
    endtask

    function automatic logic [7:0] col_of(input int k);
        return (k < 3) ? 8'(2 + k) : 8'(10 + k);
    endfunction

    task automatic check_row(input string tag, input logic [5:0][6:0] exp);
        logic [6:0] c;
        for (int k = 0; k < 6; k++) begin
            rd(col_of(k), c);
            check($sformatf("%s col%0d", tag, col_of(k)), {25'd0, c}, {25'd0, exp[5-k]});
        end
    endtask

    initial begin
        logic [15:0][6:0] row0;
        logic [6:0]       c;
        int               n, cyc, dcount, busy_low;
        int               dt [2];

`ifdef SCORE_BLANK_ZERO_EN
        row0 = {7'h4C, 7'h3A, 7'h20, 7'h20, 7'h30, 7'h20, 7'h20, 7'h20,
                7'h20, 7'h20, 7'h20, 7'h52, 7'h3A, 7'h20, 7'h20, 7'h30};
        vecs[0] = '{8'd123, 8'd45,  {7'h31, 7'h32, 7'h33, 7'h20, 7'h34, 7'h35}};
        vecs[1] = '{8'd0,   8'd255, {7'h20, 7'h20, 7'h30, 7'h32, 7'h35, 7'h35}};
        vecs[2] = '{8'd255, 8'd0,   {7'h32, 7'h35, 7'h35, 7'h20, 7'h20, 7'h30}};
        vecs[3] = '{8'd7,   8'd90,  {7'h20, 7'h20, 7'h37, 7'h20, 7'h39, 7'h30}};
        vecs[4] = '{8'd100, 8'd5,   {7'h31, 7'h30, 7'h30, 7'h20, 7'h20, 7'h35}};
`else
        row0 = {7'h4C, 7'h3A, 7'h30, 7'h30, 7'h30, 7'h20, 7'h20, 7'h20,
                7'h20, 7'h20, 7'h20, 7'h52, 7'h3A, 7'h30, 7'h30, 7'h30};
        vecs[0] = '{8'd123, 8'd45,  {7'h31, 7'h32, 7'h33, 7'h30, 7'h34, 7'h35}};
        vecs[1] = '{8'd0,   8'd255, {7'h30, 7'h30, 7'h30, 7'h32, 7'h35, 7'h35}};
        vecs[2] = '{8'd255, 8'd0,   {7'h32, 7'h35, 7'h35, 7'h30, 7'h30, 7'h30}};
        vecs[3] = '{8'd7,   8'd90,  {7'h30, 7'h30, 7'h37, 7'h30, 7'h39, 7'h30}};
        vecs[4] = '{8'd100, 8'd5,   {7'h31, 7'h30, 7'h30, 7'h30, 7'h30, 7'h35}};
`endif
        for (int i = 0; i < 16; i++) boot_tbl[i] = '{8'(i), row0[15-i]};
        boot_tbl[16] = '{8'h10, 7'h20};
        boot_tbl[17] = '{8'h87, 7'h20};
        boot_tbl[18] = '{8'hFF, 7'h20};

        // Reset and boot
        rst = 1'b1;
        bus.char_xy = 8'h00;
        bus.score_l = 8'd0;
        bus.score_r = 8'd0;
        bus.score_valid = 1'b0;
        step();
        step();
        check("reset char_code", {25'd0, bus.char_code}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd1);
        check("reset done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        wait_done(n);
        check("boot done cycle", n, 274);
        check("boot busy at done", {31'd0, bus.busy}, 32'd0);
        step();
        check("boot done width", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 19; i++) begin
            rd(boot_tbl[i].addr, c);
            check($sformatf("boot addr %0h", boot_tbl[i].addr), {25'd0, c}, {25'd0, boot_tbl[i].exp});
        end

        // Updates from IDLE, including extremes
        for (int v = 0; v < 5; v++) begin
            update(vecs[v].sl, vecs[v].sr);
            check($sformatf("upd%0d busy T+1", v), {31'd0, bus.busy}, 32'd1);
            wait_done(n);
            check($sformatf("upd%0d done T+15", v), n + 1, 15);
            check($sformatf("upd%0d busy at done", v), {31'd0, bus.busy}, 32'd0);
            check_row($sformatf("upd%0d", v), vecs[v].exp);
        end
        rd(8'h00, c);
        check("label L kept", {25'd0, c}, 32'h4C);

        // Pending requests: latest wins, CONV restarts right after the last write
        update(8'd9, 8'd0);
        cyc = 1;
        step(); step();
        cyc = 3;
        update(8'd10, 8'd0);
        step();
        cyc = 5;
        update(8'd200, 8'd0);
        cyc = 6;
        dcount = 0;
        busy_low = 0;
        while (cyc <= 36) begin
            if (bus.done === 1'b1) begin
                if (dcount < 2) dt[dcount] = cyc;
                dcount++;
            end
            if (cyc < 29 && bus.busy !== 1'b1) busy_low++;
            step();
            cyc++;
        end
        check("pend done count", dcount, 2);
        check("pend first done", dt[0], 15);
        check("pend second done", dt[1], 29);
        check("pend busy gap", busy_low, 0);
        rd(8'h02, c);
        check("pend col2", {25'd0, c}, 32'h32);
        rd(8'h03, c);
        check("pend col3", {25'd0, c}, 32'h30);
        rd(8'h04, c);
        check("pend col4", {25'd0, c}, 32'h30);

        // Read-during-write on col 2
        bus.char_xy = 8'h02;
        update(8'd123, 8'd45);
        for (int i = 0; i < 8; i++) step();
        step();
        check("collision old", {25'd0, bus.char_code}, 32'h32);
        step();
        check("collision new", {25'd0, bus.char_code}, 32'h31);
        wait_done(n);
        check("collision done", n, 4);

        // Reset in the middle of CONV
        update(8'd50, 8'd60);
        step(); step(); step();
        rst = 1'b1;
        bus.score_l = 8'd77;
        bus.score_r = 8'd3;
        step();
        check("midrst char_code", {25'd0, bus.char_code}, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd1);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        wait_done(n);
        check("midrst boot cycle", n, 274);
`ifdef SCORE_BLANK_ZERO_EN
        check_row("midrst", {7'h20, 7'h37, 7'h37, 7'h20, 7'h20, 7'h33});
`else
        check_row("midrst", {7'h30, 7'h37, 7'h37, 7'h30, 7'h30, 7'h33});
`endif
        rd(8'h55, c);
        check("midrst cleared", {25'd0, c}, 32'h20);
        rd(8'h0B, c);
        check("midrst label R", {25'd0, c}, 32'h52);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
